// File: rtl/pq_op_sequencer.sv
// pq_op_sequencer: command-side initiator for the systolic open-list priority queue.
// Checks legality, pulses the queue write/read strobes, waits out the settle interval, then returns one response.
`default_nettype none

module pq_op_sequencer #(
  parameter int DATA_WIDTH    = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  s_cmd_valid,
  output logic                  s_cmd_ready,
  input  logic [1:0]            s_cmd_op,
  input  logic [DATA_WIDTH-1:0] s_cmd_data,
  output logic                  o_wrt,
  output logic                  o_read,
  output logic [DATA_WIDTH-1:0] o_node_f,
  input  logic                  i_full,
  input  logic                  i_empty,
  input  logic [DATA_WIDTH-1:0] i_node_f,
  output logic                  m_rsp_valid,
  input  logic                  m_rsp_ready,
  output logic [DATA_WIDTH-1:0] m_rsp_data,
  output logic                  m_rsp_err,
  output logic                  o_busy
);

  localparam logic [1:0] OP_PUSH    = 2'd0;
  localparam logic [1:0] OP_POP     = 2'd1;
  localparam logic [1:0] OP_REPLACE = 2'd2;
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [3:0]            settle_cnt;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] node_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;
  logic                  accept;
  logic                  legal;

  // Legality uses the queue flags as seen in the acceptance cycle only.
  always_comb begin
    legal = 1'b0;
    case (s_cmd_op)
      OP_PUSH:    legal = !i_full;
      OP_POP:     legal = !i_empty;
      OP_REPLACE: legal = !i_empty;
      default:    legal = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    s_cmd_ready = 1'b0;
    o_wrt       = 1'b0;
    o_read      = 1'b0;
    m_rsp_valid = 1'b0;
    o_busy      = (state != IDLE);
    case (state)
      IDLE: begin
        s_cmd_ready = RSTn;
        accept      = s_cmd_valid;
        if (s_cmd_valid) begin
          state_nxt = legal ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        o_wrt     = (op_q == OP_PUSH) || (op_q == OP_REPLACE);
        o_read    = (op_q == OP_POP)  || (op_q == OP_REPLACE);
        state_nxt = SETTLE;
      end
      SETTLE: begin
        if (settle_cnt == 4'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        m_rsp_valid = 1'b1;
        if (m_rsp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      settle_cnt <= 4'd0;
      op_q       <= 2'd0;
      node_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= s_cmd_op;
        if (legal) begin
          node_q     <= s_cmd_data;
          rsp_data_q <= (s_cmd_op == OP_PUSH) ? '0 : i_node_f;
          rsp_err_q  <= 1'b0;
        end else begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end
      if (state == ISSUE) begin
        settle_cnt <= SETTLE_LOAD;
      end else if ((state == SETTLE) && (settle_cnt != 4'd0)) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
    end
  end

  assign o_node_f   = node_q;
  assign m_rsp_data = rsp_data_q;
  assign m_rsp_err  = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_pq_op_sequencer.sv
// Directed bench for pq_op_sequencer: table of single commands plus stall and mid-operation reset sequences.
`default_nettype none

module tb_pq_op_sequencer;

  localparam int DW = 32;
  localparam int SC = 2;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          s_cmd_valid = 1'b0;
  logic          s_cmd_ready;
  logic [1:0]    s_cmd_op = 2'd0;
  logic [DW-1:0] s_cmd_data = '0;
  logic          o_wrt;
  logic          o_read;
  logic [DW-1:0] o_node_f;
  logic          i_full = 1'b0;
  logic          i_empty = 1'b1;
  logic [DW-1:0] i_node_f = '0;
  logic          m_rsp_valid;
  logic          m_rsp_ready = 1'b1;
  logic [DW-1:0] m_rsp_data;
  logic          m_rsp_err;
  logic          o_busy;

  pq_op_sequencer #(.DATA_WIDTH(DW), .SETTLE_CYCLES(SC)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_cmd_op(s_cmd_op), .s_cmd_data(s_cmd_data),
    .o_wrt(o_wrt), .o_read(o_read), .o_node_f(o_node_f),
    .i_full(i_full), .i_empty(i_empty), .i_node_f(i_node_f),
    .m_rsp_valid(m_rsp_valid), .m_rsp_ready(m_rsp_ready),
    .m_rsp_data(m_rsp_data), .m_rsp_err(m_rsp_err), .o_busy(o_busy)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] data;
    logic          full;
    logic          empty;
    logic [DW-1:0] head;
    int            exp_wr;
    int            exp_rd;
    logic [DW-1:0] exp_rsp;
    logic          exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one command and return 1 ns after its acceptance edge, with the
  // queue flags flipped so late changes would corrupt a resampling design.
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] data,
                       input logic full, input logic empty, input logic [DW-1:0] head);
    @(negedge CLK);
    s_cmd_valid = 1'b1; s_cmd_op = op; s_cmd_data = data;
    i_full = full; i_empty = empty; i_node_f = head;
    chk("cmd_ready_idle", {31'd0, s_cmd_ready}, 32'd1);
    @(posedge CLK); #1;
    s_cmd_valid = 1'b0; s_cmd_data = 32'hA5A5_5A5A;
    i_full = ~full; i_empty = ~empty; i_node_f = 32'hDEAD_BEEF;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, wr, rd, exp_lat;
    logic [DW-1:0] node_at_wr;
    string tag;
    tag = $sformatf("v%0d", idx);
    node_at_wr = 32'hFFFF_0000;
    issue(v.op, v.data, v.full, v.empty, v.head);
    lat = 1; wr = 0; rd = 0;
    while (!m_rsp_valid && lat < 20) begin
      if (o_wrt) begin
        wr++;
        if (lat == 1) node_at_wr = o_node_f;
      end
      if (o_read && lat == 1) rd++;
      else if (o_read) rd += 100;
      if (o_wrt && lat != 1) wr += 100;
      @(posedge CLK); #1;
      lat++;
    end
    exp_lat = v.exp_err ? 1 : 2 + SC;
    chk({tag, "_rsp_valid"}, {31'd0, m_rsp_valid}, 32'd1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_wr_pulses"}, wr, v.exp_wr);
    chk({tag, "_rd_pulses"}, rd, v.exp_rd);
    if (v.exp_wr != 0) chk({tag, "_node_f"}, node_at_wr, v.data);
    chk({tag, "_rsp_data"}, m_rsp_data, v.exp_rsp);
    chk({tag, "_rsp_err"}, {31'd0, m_rsp_err}, {31'd0, v.exp_err});
    chk({tag, "_ready_in_resp"}, {31'd0, s_cmd_ready}, 32'd0);
    @(posedge CLK); #1;
    chk({tag, "_valid_after_hs"}, {31'd0, m_rsp_valid}, 32'd0);
    chk({tag, "_ready_after_hs"}, {31'd0, s_cmd_ready}, 32'd1);
  endtask

  initial begin
    vec_t vecs[9];
    int n;
    int seen_valid;
    //         op    data          full  empty head   wr rd rsp   err
    vecs[0] = '{2'd0, 32'd100,      1'b0, 1'b1, 32'd0, 1, 0, 32'd0, 1'b0};
    vecs[1] = '{2'd1, 32'd0,        1'b0, 1'b0, 32'd7, 0, 1, 32'd7, 1'b0};
    vecs[2] = '{2'd2, 32'd3,        1'b0, 1'b0, 32'd7, 1, 1, 32'd7, 1'b0};
    vecs[3] = '{2'd0, 32'd55,       1'b1, 1'b0, 32'd5, 0, 0, 32'd0, 1'b1};
    vecs[4] = '{2'd2, 32'd1,        1'b1, 1'b0, 32'd5, 1, 1, 32'd5, 1'b0};
    vecs[5] = '{2'd1, 32'd0,        1'b0, 1'b1, 32'd8, 0, 0, 32'd0, 1'b1};
    vecs[6] = '{2'd2, 32'd9,        1'b0, 1'b1, 32'd8, 0, 0, 32'd0, 1'b1};
    vecs[7] = '{2'd3, 32'd4,        1'b0, 1'b0, 32'd4, 0, 0, 32'd0, 1'b1};
    vecs[8] = '{2'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd6, 1, 0, 32'd0, 1'b0};

    #12;
    chk("rst_ready", {31'd0, s_cmd_ready}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_valid", {31'd0, m_rsp_valid}, 32'd0);
    chk("rst_err", {31'd0, m_rsp_err}, 32'd0);
    chk("rst_strobes", {30'd0, o_wrt, o_read}, 32'd0);
    chk("rst_node_f", o_node_f, 32'd0);
    chk("rst_rsp_data", m_rsp_data, 32'd0);
    @(negedge CLK); RSTn = 1'b1;
    @(posedge CLK); #1;
    chk("ready_after_rst", {31'd0, s_cmd_ready}, 32'd1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Response stall: data and valid must hold while m_rsp_ready is low.
    m_rsp_ready = 1'b0;
    issue(2'd1, 32'd0, 1'b0, 1'b0, 32'd42);
    n = 0;
    while (!m_rsp_valid && n < 20) begin
      @(posedge CLK); #1; n++;
    end
    chk("stall_valid_reached", {31'd0, m_rsp_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(posedge CLK); #1;
      chk("stall_valid", {31'd0, m_rsp_valid}, 32'd1);
      chk("stall_data", m_rsp_data, 32'd42);
      chk("stall_ready", {31'd0, s_cmd_ready}, 32'd0);
    end
    m_rsp_ready = 1'b1;
    @(posedge CLK); #1;
    chk("stall_release", {31'd0, m_rsp_valid}, 32'd0);

    // Reset during ISSUE of a replace: both strobes drop asynchronously.
    issue(2'd2, 32'd11, 1'b0, 1'b0, 32'd2);
    chk("issue_strobes", {30'd0, o_wrt, o_read}, 32'd3);
    #2 RSTn = 1'b0;
    #1;
    chk("rst_issue_strobes", {30'd0, o_wrt, o_read}, 32'd0);
    chk("rst_issue_busy", {31'd0, o_busy}, 32'd0);
    @(negedge CLK); RSTn = 1'b1;

    // Reset during SETTLE of a push: no response ever appears.
    issue(2'd0, 32'd77, 1'b0, 1'b1, 32'd0);
    @(posedge CLK); #1;
    chk("settle_busy", {31'd0, o_busy}, 32'd1);
    #2 RSTn = 1'b0;
    #1;
    chk("rst_settle_valid", {31'd0, m_rsp_valid}, 32'd0);
    chk("rst_settle_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_settle_ready", {31'd0, s_cmd_ready}, 32'd0);
    chk("rst_settle_node", o_node_f, 32'd0);
    @(negedge CLK); RSTn = 1'b1;
    seen_valid = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      if (m_rsp_valid) seen_valid++;
    end
    chk("no_rsp_after_rst", seen_valid, 32'd0);
    chk("ready_after_mid_rst", {31'd0, s_cmd_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
